reg_write_sched: RTL
====================

REG_WRITE_SCHED -- requirements
Module: reg_write_sched

Interface
REQ-001 Parameter DATA_W, default 64, register data width.
REQ-002 Parameter RNONE, default 4'hF, register ID meaning "no register".
REQ-003 clk_i  input  1  single clock; all state updates on posedge.
REQ-004 rst_i  input  1  synchronous reset, active-high.
REQ-005 wb_valid_i  input  1  writeback command valid.
REQ-006 wb_ready_o  output  1  scheduler can accept a command this cycle.
REQ-007 dstE_i  input  4  destination for valE; RNONE = no write.
REQ-008 valE_i  input  DATA_W  ALU result.
REQ-009 dstM_i  input  4  destination for valM; RNONE = no write.
REQ-010 valM_i  input  DATA_W  memory load result.
REQ-011 rf_we_o  output  1  register file write enable, one write per cycle.
REQ-012 rf_waddr_o  output  4  register file write address.
REQ-013 rf_wdata_o  output  DATA_W  register file write data.
REQ-014 srcA_i, srcB_i  input  4 each  decode read addresses to check.
REQ-015 hazA_o, hazB_o  output  1 each  the read address has a pending, unwritten write.
REQ-016 busy_o  output  1  state is not IDLE.

Function
REQ-017 The block SHALL serialize the two writeback results of one instruction onto the single register file write port.
REQ-018 FSM states SHALL be IDLE, WR_E and WR_M, held in a state register.
REQ-019 A command SHALL be accepted on a posedge where wb_valid_i and wb_ready_o are both 1; the block SHALL latch dstE, valE, dstM and valM at that edge.
REQ-020 wb_ready_o SHALL be 1 in IDLE, in WR_M, and in WR_E when no M write is pending; it SHALL be 0 otherwise.
REQ-021 On acceptance, the next state SHALL be WR_E if the latched dstE is not RNONE and differs from dstM; else WR_M if dstM is not RNONE; else IDLE (no write).
REQ-022 If dstE equals dstM and neither is RNONE, the block SHALL drop the E write and write only valM (M priority, popq %rsp semantics).
REQ-023 From WR_E, the next state SHALL be WR_M if an M write is pending; otherwise the block SHALL take the accept decision of REQ-021 if a command is accepted that cycle, else go to IDLE.
REQ-024 From WR_M, the block SHALL take the accept decision of REQ-021 if a command is accepted that cycle, else go to IDLE.
REQ-025 rf_we_o SHALL be 1 exactly in WR_E and WR_M, decoded from registered state only, with no combinational path from wb_* inputs.
REQ-026 In WR_E, rf_waddr_o/rf_wdata_o SHALL be the latched dstE/valE; in WR_M, the latched dstM/valM; in IDLE, 4'h0/0.
REQ-027 Latency: a command accepted at edge N SHALL write E in cycle N+1 and M in cycle N+1 (no E write) or N+2.
REQ-028 Throughput: back-to-back commands SHALL sustain one write per cycle with no idle bubble.
REQ-029 hazA_o SHALL be 1 iff srcA_i is not RNONE and equals a latched destination whose write has not yet been performed, counting the write in the current cycle as pending; hazB_o likewise for srcB_i. Both are combinational.
REQ-030 A dropped E destination (REQ-022) SHALL still flag a hazard through its matching dstM.
REQ-031 A command with both destinations RNONE SHALL be accepted, SHALL produce no write and SHALL leave the state at IDLE.

Reset
REQ-032 While rst_i is 1 at a posedge: state SHALL be IDLE and both latched destinations RNONE.
REQ-033 While rst_i is 1: rf_we_o, busy_o, hazA_o and hazB_o SHALL be 0, and wb_ready_o SHALL be 0.
REQ-034 wb_ready_o SHALL be 1 in the first cycle after rst_i falls.
REQ-035 A reset during WR_E or WR_M SHALL abort the pending writes with no further rf_we_o pulse.

Verification
REQ-036 OPq: dstE=3, valE=0x55, dstM=F -> one cycle later rf_we_o=1, waddr=3, wdata=0x55; next cycle IDLE, busy_o=0.
REQ-037 mrmovq then irmovq back-to-back: cmd1 dstE=F, dstM=7, valM=0xAA; cmd2 dstE=2, valE=0x11, dstM=F -> writes (7,0xAA) then (2,0x11) in consecutive cycles; wb_ready_o stays 1.
REQ-038 popq: dstE=4, valE=0x100, dstM=5, valM=0x9 -> WR_E (4,0x100) then WR_M (5,0x9); wb_ready_o=0 during WR_E; hazA_o=1 for srcA_i=5 in both cycles.
REQ-039 popq %rsp: dstE=4, dstM=4, valM=0x77 -> single write (4,0x77), no write of valE; hazB_o=1 for srcB_i=4 that cycle.
REQ-040 NOP-type command (both dst F) -> no rf_we_o pulse, hazards 0 for all srcX_i; then rst_i asserted in WR_E of a popq -> no further writes, wb_ready_o=1 the cycle after release.

Source files
------------

// File: rtl/reg_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_sched
// Purpose  : Serializes the E and M writeback results of one instruction onto
//            a single register file write port and flags pending-write hazards.
// Revision : 1.0
// ============================================================================
module reg_write_sched #(
    parameter int         DATA_W = 64,
    parameter logic [3:0] RNONE  = 4'hF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_valid_i,
    output logic              wb_ready_o,
    input  logic [3:0]        dstE_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [3:0]        dstM_i,
    input  logic [DATA_W-1:0] valM_i,
    output logic              rf_we_o,
    output logic [3:0]        rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic [3:0]        srcA_i,
    input  logic [3:0]        srcB_i,
    output logic              hazA_o,
    output logic              hazB_o,
    output logic              busy_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WR_E = 2'd1;
    localparam logic [1:0] c_WR_M = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [3:0]        r_dst_e;
    logic [3:0]        r_dst_m;
    logic [DATA_W-1:0] r_val_e;
    logic [DATA_W-1:0] r_val_m;
    logic              w_acc;
    logic              w_m_pending;

    // E is dropped when both results target the same register: M wins.
    function automatic logic [1:0] f_accept_state(input logic [3:0] de, input logic [3:0] dm);
        if (de != RNONE && de != dm)
            return c_WR_E;
        else if (dm != RNONE)
            return c_WR_M;
        else
            return c_IDLE;
    endfunction

    function automatic logic f_haz(input logic [3:0] src, input logic [1:0] st,
                                   input logic [3:0] de, input logic [3:0] dm);
        if (src == RNONE)
            return 1'b0;
        else if (st == c_WR_E)
            return (src == de) || (src == dm);
        else if (st == c_WR_M)
            return src == dm;
        else
            return 1'b0;
    endfunction

    assign w_m_pending = (r_dst_m != RNONE);
    assign wb_ready_o  = !rst_i && ((r_state == c_IDLE) || (r_state == c_WR_M) ||
                                    ((r_state == c_WR_E) && !w_m_pending));
    assign w_acc       = wb_valid_i && wb_ready_o;

    always_comb begin
        w_next = c_IDLE;
        case (r_state)
            c_IDLE:  w_next = w_acc ? f_accept_state(dstE_i, dstM_i) : c_IDLE;
            c_WR_E: begin
                if (w_m_pending)
                    w_next = c_WR_M;
                else if (w_acc)
                    w_next = f_accept_state(dstE_i, dstM_i);
                else
                    w_next = c_IDLE;
            end
            c_WR_M:  w_next = w_acc ? f_accept_state(dstE_i, dstM_i) : c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_dst_e <= RNONE;
            r_dst_m <= RNONE;
            r_val_e <= '0;
            r_val_m <= '0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_dst_e <= dstE_i;
                r_dst_m <= dstM_i;
                r_val_e <= valE_i;
                r_val_m <= valM_i;
            end
        end
    end

    // Write port is driven from registered state only.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 4'h0;
        rf_wdata_o = '0;
        case (r_state)
            c_WR_E: begin
                rf_we_o    = !rst_i;
                rf_waddr_o = r_dst_e;
                rf_wdata_o = r_val_e;
            end
            c_WR_M: begin
                rf_we_o    = !rst_i;
                rf_waddr_o = r_dst_m;
                rf_wdata_o = r_val_m;
            end
            default: ;
        endcase
    end

    assign busy_o = !rst_i && (r_state != c_IDLE);
    assign hazA_o = !rst_i && f_haz(srcA_i, r_state, r_dst_e, r_dst_m);
    assign hazB_o = !rst_i && f_haz(srcB_i, r_state, r_dst_e, r_dst_m);

endmodule
`default_nettype wire
